// File: rtl/execute_button_ctrl.sv
// Execute button controller: sprite ROM address sequencing with a 2-stage pixel
// pipeline, plus the mouse-driven hover/press/fire/cooldown state machine.
module execute_button_ctrl #(
  parameter logic [9:0] BTN_X       = 10'd520,
  parameter logic [9:0] BTN_Y       = 10'd440,
  parameter int         SPR_W       = 60,
  parameter int         SPR_H       = 20,
  parameter int         COOL_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  MouseX,
  input  logic [9:0]  MouseY,
  input  logic        mouse_btn,
  input  logic        enable,
  output logic [10:0] rom_addr,
  input  logic        rom_data,
  output logic        pixel_on,
  output logic        in_box,
  output logic [1:0]  shade,
  output logic        execute_pulse
);

  localparam logic [9:0] SPR_W10 = 10'(SPR_W);
  localparam logic [9:0] SPR_H10 = 10'(SPR_H);
  localparam int         CW      = $clog2(COOL_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, HOVER, PRESSED, FIRE, COOLDOWN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [10:0]   rom_addr_q, rom_addr_d;
  logic          hit1_q, in_box_q, pixel_on_q;
  logic [1:0]    shade_q, shade_d;
  logic          pulse_q, pulse_d;
  logic          btn_s1_q, btn_s2_q, btn_prev_q;
  logic          frame_s_q, frame_prev_q;

  logic [9:0]  dx, dy, mdx, mdy;
  logic [10:0] dy11;
  logic        hit, cursor_in, btn_rise, btn_fall, frame_edge;

  // Unsigned wrap-around makes anything left of / above the box a miss too.
  always_comb begin
    dx         = DrawX - BTN_X;
    dy         = DrawY - BTN_Y;
    dy11       = {1'b0, dy};
    hit        = (dx < SPR_W10) && (dy < SPR_H10);
    rom_addr_d = hit ? ((dy11 << 6) - (dy11 << 2) + {1'b0, dx}) : 11'd0;
    mdx        = MouseX - BTN_X;
    mdy        = MouseY - BTN_Y;
    cursor_in  = (mdx < SPR_W10) && (mdy < SPR_H10);
    btn_rise   = btn_s2_q & ~btn_prev_q;
    btn_fall   = ~btn_s2_q & btn_prev_q;
    frame_edge = frame_s_q & ~frame_prev_q;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE:     if (cursor_in) state_d = HOVER;
      HOVER: begin
        if (!cursor_in)    state_d = IDLE;
        else if (btn_rise) state_d = PRESSED;
      end
      PRESSED:  if (btn_fall) state_d = cursor_in ? FIRE : IDLE;
      FIRE: begin
        state_d = COOLDOWN;
        count_d = CW'(COOL_FRAMES);
      end
      COOLDOWN: begin
        if (count_q == '0)    state_d = IDLE;
        else if (frame_edge) count_d = count_q - CW'(1);
      end
      default:  state_d = IDLE;
    endcase
    // A pulse already issued in FIRE must still be followed by a cooldown.
    if (!enable && state_q != COOLDOWN && state_q != FIRE) state_d = IDLE;

    pulse_d = (state_d == FIRE);
    case (state_d)
      IDLE:          shade_d = 2'b00;
      HOVER:         shade_d = 2'b01;
      PRESSED, FIRE: shade_d = 2'b10;
      default:       shade_d = 2'b11;
    endcase
    if (!enable) shade_d = 2'b11;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rom_addr_q   <= '0;
      hit1_q       <= 1'b0;
      in_box_q     <= 1'b0;
      pixel_on_q   <= 1'b0;
      shade_q      <= 2'b00;
      pulse_q      <= 1'b0;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_prev_q   <= 1'b0;
      frame_s_q    <= 1'b0;
      frame_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rom_addr_q   <= rom_addr_d;
      hit1_q       <= hit;
      in_box_q     <= hit1_q;
      pixel_on_q   <= hit1_q & rom_data;
      shade_q      <= shade_d;
      pulse_q      <= pulse_d;
      btn_s1_q     <= mouse_btn;
      btn_s2_q     <= btn_s1_q;
      btn_prev_q   <= btn_s2_q;
      frame_s_q    <= frame_clk;
      frame_prev_q <= frame_s_q;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign in_box        = in_box_q;
  assign pixel_on      = pixel_on_q;
  assign shade         = shade_q;
  assign execute_pulse = pulse_q;

endmodule

// File: tb/tb_execute_button_ctrl.sv
// Self-checking bench for execute_button_ctrl: random ROM image and raster
// pixels against a geometric model, plus directed and random click scenarios.
module tb_execute_button_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_clk;
  logic [9:0]  DrawX, DrawY, MouseX, MouseY;
  logic        mouse_btn, enable;
  logic [10:0] rom_addr;
  logic        rom_data;
  logic        pixel_on, in_box;
  logic [1:0]  shade;
  logic        execute_pulse;

  logic rom_mem [0:2047];
  int   tests = 0;
  int   fails = 0;
  int   pulse_cnt = 0;
  logic [1:0] pulse_shade = 2'b00;

  execute_button_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .MouseX(MouseX), .MouseY(MouseY),
    .mouse_btn(mouse_btn), .enable(enable), .rom_addr(rom_addr),
    .rom_data(rom_data), .pixel_on(pixel_on), .in_box(in_box),
    .shade(shade), .execute_pulse(execute_pulse)
  );

  assign rom_data = rom_mem[rom_addr];

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (execute_pulse === 1'b1) begin
      pulse_cnt++;
      pulse_shade = shade;
    end
  end

  function automatic bit box(input int x, input int y);
    return (x >= 520) && (x < 580) && (y >= 440) && (y < 460);
  endfunction

  function automatic int addr_of(input int x, input int y);
    return box(x, y) ? (y - 440) * 60 + (x - 520) : 0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_mouse(input int x, input int y);
    MouseX = 10'(x);
    MouseY = 10'(y);
  endtask

  task automatic press_btn();
    mouse_btn = 1'b1;
    cyc(6);
  endtask

  task automatic release_btn();
    mouse_btn = 1'b0;
    cyc(6);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_clk = 1'b1;
      cyc(3);
      frame_clk = 1'b0;
      cyc(3);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    cyc(2);
    Reset_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (rom_addr !== 11'd0 || in_box !== 1'b0 || pixel_on !== 1'b0 ||
        shade !== 2'b00 || execute_pulse !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: addr=%0d in_box=%b pix=%b shade=%b pulse=%b, want 0/0/0/00/0",
               rom_addr, in_box, pixel_on, shade, execute_pulse);
    end
    cyc(2);
    Reset_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_pixel_pipeline();
    int px[$];
    int py[$];
    int qx[$];
    int qy[$];
    int ex, ey;
    bit e_box, e_pix;
    int e_addr;
    px = '{520, 579, 519, 580, 520, 0, 0};
    py = '{440, 459, 440, 440, 439, 0, 0};
    for (int y = 437; y < 463; y++)
      for (int x = 515; x < 586; x++) begin
        px.push_back(x);
        py.push_back(y);
      end
    for (int i = 0; i < 400; i++) begin
      px.push_back(int'($urandom_range(500, 600)));
      py.push_back(int'($urandom_range(430, 470)));
    end
    for (int i = 0; i < 100; i++) begin
      px.push_back(int'($urandom_range(0, 1023)));
      py.push_back(int'($urandom_range(0, 1023)));
    end
    px.push_back(0); py.push_back(0);
    px.push_back(0); py.push_back(0);
    for (int i = 0; i < px.size(); i++) begin
      @(negedge Clk);
      if (qx.size() >= 1) begin
        e_addr = addr_of(qx[qx.size()-1], qy[qy.size()-1]);
        tests++;
        if (rom_addr !== 11'(e_addr)) begin
          fails++;
          $display("[TB] FAIL rom_addr (%0d,%0d): got %0d want %0d",
                   qx[qx.size()-1], qy[qy.size()-1], rom_addr, e_addr);
        end
      end
      if (qx.size() >= 2) begin
        ex = qx.pop_front();
        ey = qy.pop_front();
        e_box = box(ex, ey);
        e_pix = e_box && rom_mem[addr_of(ex, ey)];
        tests++;
        if (in_box !== e_box || pixel_on !== e_pix) begin
          fails++;
          $display("[TB] FAIL pixel (%0d,%0d): in_box=%b pixel_on=%b want %b %b",
                   ex, ey, in_box, pixel_on, e_box, e_pix);
        end
      end
      DrawX = 10'(px[i]);
      DrawY = 10'(py[i]);
      qx.push_back(px[i]);
      qy.push_back(py[i]);
    end
  endtask

  task automatic test_click_fire();
    int p0;
    p0 = pulse_cnt;
    set_mouse(550, 450);
    cyc(2);
    tests++;
    if (shade !== 2'b01) begin
      fails++; $display("[TB] FAIL hover_shade: got %b want 01", shade);
    end
    press_btn();
    tests++;
    if (shade !== 2'b10) begin
      fails++; $display("[TB] FAIL pressed_shade: got %b want 10", shade);
    end
    release_btn();
    tests++;
    if (pulse_cnt - p0 !== 1 || pulse_shade !== 2'b10) begin
      fails++;
      $display("[TB] FAIL fire_pulse: pulses=%0d shade_at_pulse=%b want 1 10", pulse_cnt - p0, pulse_shade);
    end
    tests++;
    if (shade !== 2'b11) begin
      fails++; $display("[TB] FAIL cooldown_shade: got %b want 11", shade);
    end
    set_mouse(100, 100);
    tick(29);
    tests++;
    if (shade !== 2'b11) begin
      fails++; $display("[TB] FAIL cooldown_29_frames: got %b want 11", shade);
    end
    tick(1);
    tests++;
    if (shade !== 2'b00 || pulse_cnt - p0 !== 1) begin
      fails++;
      $display("[TB] FAIL cooldown_done: shade=%b pulses=%0d want 00 1", shade, pulse_cnt - p0);
    end
  endtask

  task automatic test_drag_cancel();
    int p0;
    p0 = pulse_cnt;
    set_mouse(550, 450);
    cyc(2);
    press_btn();
    set_mouse(100, 100);
    cyc(3);
    tests++;
    if (shade !== 2'b10) begin
      fails++; $display("[TB] FAIL drag_held_shade: got %b want 10", shade);
    end
    release_btn();
    tests++;
    if (shade !== 2'b00 || pulse_cnt !== p0) begin
      fails++;
      $display("[TB] FAIL drag_cancel: shade=%b pulses=%0d want 00 0", shade, pulse_cnt - p0);
    end
  endtask

  task automatic test_cooldown_clicks();
    int p0;
    p0 = pulse_cnt;
    set_mouse(550, 450);
    cyc(2);
    press_btn();
    release_btn();
    for (int k = 0; k < 5; k++) begin
      press_btn();
      release_btn();
      tick(1);
    end
    tick(24);
    tests++;
    if (pulse_cnt - p0 !== 1 || shade !== 2'b11) begin
      fails++;
      $display("[TB] FAIL cooldown_clicks: pulses=%0d shade=%b want 1 11", pulse_cnt - p0, shade);
    end
    tick(1);
    tests++;
    if (shade !== 2'b01) begin
      fails++; $display("[TB] FAIL rehover_after_cooldown: got %b want 01", shade);
    end
    press_btn();
    release_btn();
    tests++;
    if (pulse_cnt - p0 !== 2) begin
      fails++; $display("[TB] FAIL click_after_cooldown: pulses=%0d want 2", pulse_cnt - p0);
    end
    set_mouse(100, 100);
    do_reset();
  endtask

  task automatic test_enable();
    int p0;
    p0 = pulse_cnt;
    set_mouse(550, 450);
    cyc(2);
    enable = 1'b0;
    cyc(2);
    tests++;
    if (shade !== 2'b11) begin
      fails++; $display("[TB] FAIL disabled_shade: got %b want 11", shade);
    end
    press_btn();
    release_btn();
    enable = 1'b1;
    cyc(2);
    tests++;
    if (shade !== 2'b01 || pulse_cnt !== p0) begin
      fails++;
      $display("[TB] FAIL disabled_click: shade=%b pulses=%0d want 01 0", shade, pulse_cnt - p0);
    end
    press_btn();
    enable = 1'b0;
    cyc(2);
    release_btn();
    enable = 1'b1;
    cyc(2);
    tests++;
    if (shade !== 2'b01 || pulse_cnt !== p0) begin
      fails++;
      $display("[TB] FAIL disable_while_pressed: shade=%b pulses=%0d want 01 0", shade, pulse_cnt - p0);
    end
    set_mouse(100, 100);
    cyc(2);
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pulse_cnt;
    DrawX = 10'd550;
    DrawY = 10'd450;
    set_mouse(550, 450);
    cyc(2);
    press_btn();
    #1 Reset_n = 1'b0;
    #1;
    tests++;
    if (shade !== 2'b00 || execute_pulse !== 1'b0 || rom_addr !== 11'd0 || in_box !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_pressed: shade=%b pulse=%b addr=%0d in_box=%b want 00 0 0 0",
               shade, execute_pulse, rom_addr, in_box);
    end
    mouse_btn = 1'b0;
    cyc(4);
    Reset_n = 1'b1;
    cyc(6);
    tests++;
    if (pulse_cnt !== p0 || shade !== 2'b01) begin
      fails++;
      $display("[TB] FAIL no_pulse_after_reset: pulses=%0d shade=%b want 0 01", pulse_cnt - p0, shade);
    end
    press_btn();
    release_btn();
    set_mouse(100, 100);
    tick(13);
    tests++;
    if (pulse_cnt - p0 !== 1 || shade !== 2'b11) begin
      fails++;
      $display("[TB] FAIL mid_cooldown_setup: pulses=%0d shade=%b want 1 11", pulse_cnt - p0, shade);
    end
    #1 Reset_n = 1'b0;
    #1;
    tests++;
    if (shade !== 2'b00 || execute_pulse !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_cooldown: shade=%b pulse=%b want 00 0", shade, execute_pulse);
    end
    cyc(2);
    Reset_n = 1'b1;
    tick(2);
    tests++;
    if (shade !== 2'b00) begin
      fails++; $display("[TB] FAIL idle_after_cooldown_reset: got %b want 00", shade);
    end
  endtask

  task automatic test_random_clicks();
    bit   p_in, r_in, e_fire;
    int   p0;
    logic [1:0] e_shade;
    for (int it = 0; it < 8; it++) begin
      p_in = 1'($urandom_range(0, 1));
      r_in = 1'($urandom_range(0, 1));
      p0 = pulse_cnt;
      if (p_in) set_mouse(int'($urandom_range(520, 579)), int'($urandom_range(440, 459)));
      else      set_mouse(int'($urandom_range(0, 500)), int'($urandom_range(0, 420)));
      cyc(3);
      press_btn();
      if (r_in) set_mouse(int'($urandom_range(520, 579)), int'($urandom_range(440, 459)));
      else      set_mouse(int'($urandom_range(600, 1000)), int'($urandom_range(0, 430)));
      cyc(3);
      release_btn();
      e_fire  = p_in && r_in;
      e_shade = e_fire ? 2'b11 : ((!p_in && r_in) ? 2'b01 : 2'b00);
      tests++;
      if (pulse_cnt - p0 !== int'(e_fire) || shade !== e_shade) begin
        fails++;
        $display("[TB] FAIL random_click %0d (press_in=%0d rel_in=%0d): pulses=%0d shade=%b want %0d %b",
                 it, p_in, r_in, pulse_cnt - p0, shade, e_fire, e_shade);
      end
      set_mouse(100, 100);
      cyc(2);
      if (e_fire) tick(30);
    end
  endtask

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    DrawX     = 10'd550;
    DrawY     = 10'd450;
    MouseX    = 10'd100;
    MouseY    = 10'd100;
    mouse_btn = 1'b0;
    enable    = 1'b1;
    for (int i = 0; i < 2048; i++) rom_mem[i] = 1'($urandom_range(0, 1));
    test_reset();
    test_pixel_pipeline();
    test_click_fire();
    test_drag_cancel();
    test_cooldown_clicks();
    test_enable();
    test_reset_mid();
    test_random_clicks();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
